// File: rtl/mem_pkg.sv
// Shared types and lane helpers for the MEM-stage load/store unit.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    M2R_ALU  = 2'b00,
    M2R_LOAD = 2'b01,
    M2R_PC4  = 2'b10
  } m2r_e;

  function automatic logic misaligned(size_e size, logic [1:0] off);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      SZ_W:    return off != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(size_e size, logic [1:0] off);
    case (size)
      SZ_B:    return 4'b0001 << off;
      SZ_H:    return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicating the datum puts it on every lane; byte enables pick the one written.
  function automatic logic [31:0] store_data(size_e size, logic [31:0] wdata);
    case (size)
      SZ_B:    return {4{wdata[7:0]}};
      SZ_H:    return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Load alignment: selects the addressed lane of a read word and sign/zero-extends it.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] data
);

  logic [31:0] sh;

  always_comb begin
    sh = rdata >> {addr, 3'b000};
    case (size_e'(size))
      SZ_B:    data = uns ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      SZ_H:    data = uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: data = sh;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM-stage load/store unit: EX op -> valid/ready dmem transaction -> registered WB result.
module mem_access
  import mem_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              flush_i,
  input  logic              ex_memrd,
  input  logic              ex_memwr,
  input  logic [1:0]        ex_size,
  input  logic              ex_unsigned,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [31:0]       ex_wdata,
  input  logic [31:0]       ex_alu,
  input  logic [1:0]        ex_mem2reg,
  input  logic              ex_regw,
  input  logic [4:0]        ex_rd,
  output logic              stall_o,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ready,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata,
  output logic              wb_valid,
  output logic [1:0]        wb_mem2reg,
  output logic              wb_regw,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_result,
  output logic              misalign_o,
  output logic              bus_err_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             timeout;
  logic             is_mem, misal;
  logic             start, pass, done_mem, abort;
  logic             flush_pend;

  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] alu_q;
  logic [1:0]  m2r_q;
  logic        regw_q;
  logic [4:0]  rd_q;
  logic [31:0] ld_data;

  assign is_mem  = ex_memrd | ex_memwr;
  assign misal   = is_mem & misaligned(size_e'(ex_size), ex_addr[1:0]);
  assign timeout = (cnt == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    stall_o   = 1'b0;
    dmem_req  = 1'b0;
    start     = 1'b0;
    pass      = 1'b0;
    done_mem  = 1'b0;
    abort     = 1'b0;
    unique case (state)
      IDLE: begin
        // Qualified by rst so stall_o drops with the asynchronous reset too.
        if (ex_valid && rst) begin
          if (is_mem && !misal && !flush_i) begin
            start     = 1'b1;
            stall_o   = 1'b1;
            state_nxt = REQ;
          end else begin
            pass = 1'b1;
          end
        end
      end
      REQ: begin
        if (timeout) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else begin
          dmem_req = 1'b1;
          if (dmem_ready && dmem_we) begin
            done_mem  = 1'b1;
            state_nxt = IDLE;
          end else begin
            stall_o = 1'b1;
            if (dmem_ready) state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (dmem_rvalid) begin
          done_mem  = 1'b1;
          state_nxt = IDLE;
        end else if (timeout) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else begin
          stall_o = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  load_align u_align (
    .rdata (dmem_rdata),
    .addr  (off_q),
    .size  (size_q),
    .uns   (uns_q),
    .data  (ld_data)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      off_q      <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      alu_q      <= '0;
      m2r_q      <= '0;
      regw_q     <= 1'b0;
      rd_q       <= '0;
      flush_pend <= 1'b0;
      cnt        <= '0;
      wb_valid   <= 1'b0;
      wb_mem2reg <= '0;
      wb_regw    <= 1'b0;
      wb_rd      <= '0;
      wb_result  <= '0;
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
    end else begin
      wb_valid   <= 1'b0;
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;

      if (start) begin
        dmem_we    <= ex_memwr;
        dmem_addr  <= {ex_addr[ADDR_W-1:2], 2'b00};
        dmem_be    <= byte_en(size_e'(ex_size), ex_addr[1:0]);
        dmem_wdata <= store_data(size_e'(ex_size), ex_wdata);
        off_q      <= ex_addr[1:0];
        size_q     <= ex_size;
        uns_q      <= ex_unsigned;
        alu_q      <= ex_alu;
        m2r_q      <= ex_mem2reg;
        regw_q     <= ex_regw;
        rd_q       <= ex_rd;
        flush_pend <= flush_i;
        cnt        <= '0;
      end else if (state != IDLE) begin
        flush_pend <= (state_nxt == IDLE) ? 1'b0 : (flush_pend | flush_i);
        cnt        <= cnt + 1'b1;
      end

      if (pass) begin
        wb_valid   <= 1'b1;
        wb_result  <= ex_alu;
        wb_mem2reg <= ex_mem2reg;
        wb_rd      <= ex_rd;
        wb_regw    <= ex_regw & ~flush_i & ~misal;
        misalign_o <= misal;
      end

      if (done_mem || abort) begin
        wb_valid   <= 1'b1;
        wb_result  <= (dmem_we || abort) ? alu_q : ld_data;
        wb_mem2reg <= m2r_q;
        wb_rd      <= rd_q;
        wb_regw    <= regw_q & ~flush_pend & ~flush_i & ~abort;
        bus_err_o  <= abort;
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: single-cycle vector table plus multi-cycle bus sequences.
module tb_mem_access;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, flush_i, ex_memrd, ex_memwr, ex_unsigned, ex_regw;
  logic [1:0]  ex_size, ex_mem2reg;
  logic [31:0] ex_addr, ex_wdata, ex_alu;
  logic [4:0]  ex_rd;
  logic        stall_o, dmem_req, dmem_we, dmem_ready, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        wb_valid, wb_regw, misalign_o, bus_err_o;
  logic [1:0]  wb_mem2reg;
  logic [4:0]  wb_rd;
  logic [31:0] wb_result;

  int checks = 0;
  int errors = 0;
  int writes = 0;

  mem_access #(.ADDR_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .flush_i(flush_i),
    .ex_memrd(ex_memrd), .ex_memwr(ex_memwr), .ex_size(ex_size),
    .ex_unsigned(ex_unsigned), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .ex_alu(ex_alu), .ex_mem2reg(ex_mem2reg), .ex_regw(ex_regw), .ex_rd(ex_rd),
    .stall_o(stall_o), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_mem2reg(wb_mem2reg), .wb_regw(wb_regw),
    .wb_rd(wb_rd), .wb_result(wb_result), .misalign_o(misalign_o),
    .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (dmem_req && dmem_ready && dmem_we) writes++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rd_op;
    logic        wr_op;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] alu;
    logic [1:0]  m2r;
    logic        regw;
    logic [4:0]  rd;
    logic        flush;
    logic [31:0] exp_result;
    logic        exp_regw;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic rd_op, input logic wr_op, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] alu, input logic [1:0] m2r, input logic regw,
                        input logic [4:0] rd);
    ex_valid    = 1'b1;
    ex_memrd    = rd_op;
    ex_memwr    = wr_op;
    ex_size     = size;
    ex_unsigned = uns;
    ex_addr     = addr;
    ex_wdata    = wdata;
    ex_alu      = alu;
    ex_mem2reg  = m2r;
    ex_regw     = regw;
    ex_rd       = rd;
  endtask

  initial begin
    int hi;
    rst = 1'b0;
    ex_valid = 0; flush_i = 0; ex_memrd = 0; ex_memwr = 0; ex_size = 0; ex_unsigned = 0;
    ex_addr = 0; ex_wdata = 0; ex_alu = 0; ex_mem2reg = 0; ex_regw = 0; ex_rd = 0;
    dmem_ready = 0; dmem_rvalid = 0; dmem_rdata = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", dmem_req, 0);
    check("rst_stall", stall_o, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_result", wb_result, 0);
    check("rst_pulses", {misalign_o, bus_err_o}, 0);
    rst = 1'b1;
    tick();

    //          rd wr size uns addr          alu           m2r   rw rd  fl  result        rw mis
    vecs[0] = '{0, 0, 2'b10, 0, 32'h0,       32'h1234,     2'b00, 1, 5, 0, 32'h1234,     1, 0};
    vecs[1] = '{0, 0, 2'b10, 0, 32'h0,       32'h0040_0008, 2'b10, 1, 1, 0, 32'h0040_0008, 1, 0};
    vecs[2] = '{0, 0, 2'b10, 0, 32'h0,       32'hAAAA_5555, 2'b00, 1, 7, 1, 32'hAAAA_5555, 0, 0};
    vecs[3] = '{1, 0, 2'b10, 0, 32'h3001,    32'h3001,     2'b01, 1, 8, 0, 32'h3001,     0, 1};
    vecs[4] = '{1, 0, 2'b01, 1, 32'h21,      32'h21,       2'b01, 1, 9, 0, 32'h21,       0, 1};
    vecs[5] = '{1, 0, 2'b11, 0, 32'h40,      32'h40,       2'b01, 1, 10, 0, 32'h40,      0, 1};
    vecs[6] = '{0, 1, 2'b10, 0, 32'h44,      32'h44,       2'b00, 1, 11, 1, 32'h44,      0, 0};
    vecs[7] = '{1, 0, 2'b00, 0, 32'h13,      32'h13,       2'b01, 1, 12, 1, 32'h13,      0, 0};

    for (int i = 0; i < 8; i++) begin
      set_op(vecs[i].rd_op, vecs[i].wr_op, vecs[i].size, vecs[i].uns, vecs[i].addr,
             32'h0, vecs[i].alu, vecs[i].m2r, vecs[i].regw, vecs[i].rd);
      flush_i = vecs[i].flush;
      #1;
      check($sformatf("vec%0d_stall", i), stall_o, 0);
      check($sformatf("vec%0d_req", i), dmem_req, 0);
      tick();
      ex_valid = 0;
      flush_i  = 0;
      check($sformatf("vec%0d_wb_valid", i), wb_valid, 1);
      check($sformatf("vec%0d_result", i), wb_result, vecs[i].exp_result);
      check($sformatf("vec%0d_regw", i), wb_regw, vecs[i].exp_regw);
      check($sformatf("vec%0d_rd", i), wb_rd, vecs[i].rd);
      check($sformatf("vec%0d_m2r", i), wb_mem2reg, vecs[i].m2r);
      check($sformatf("vec%0d_misalign", i), misalign_o, vecs[i].exp_mis);
    end
    tick();
    check("idle_wb_valid", wb_valid, 0);
    check("idle_misalign", misalign_o, 0);

    // Signed byte load at 0x1003
    set_op(1, 0, 2'b00, 0, 32'h1003, 32'h0, 32'hDEAD, M2R_LOAD, 1, 3);
    #1 check("lb_stall_c0", stall_o, 1);
    tick();
    check("lb_req_c1", dmem_req, 1);
    check("lb_addr", dmem_addr, 32'h1000);
    check("lb_be", dmem_be, 4'b1000);
    check("lb_we", dmem_we, 0);
    check("lb_stall_c1", stall_o, 1);
    tick();
    dmem_ready = 1;
    #1 check("lb_stall_c2", stall_o, 1);
    tick();
    dmem_ready = 0;
    check("lb_req_wait", dmem_req, 0);
    check("lb_stall_c3", stall_o, 1);
    tick();
    dmem_rvalid = 1;
    dmem_rdata  = 32'h80FF_FFFF;
    #1 check("lb_stall_c4", stall_o, 0);
    tick();
    dmem_rvalid = 0;
    ex_valid    = 0;
    check("lb_wb_valid", wb_valid, 1);
    check("lb_result", wb_result, 32'hFFFF_FF80);
    check("lb_regw", wb_regw, 1);
    check("lb_rd", wb_rd, 3);

    // Half store 0xBEEF at 0x2002 with ready low for three cycles
    writes = 0;
    set_op(0, 1, 2'b01, 0, 32'h2002, 32'h0000_BEEF, 32'h55, M2R_ALU, 1, 4);
    #1 check("sh_stall_c0", stall_o, 1);
    tick();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("sh_req_%0d", k), dmem_req, 1);
      check($sformatf("sh_be_%0d", k), dmem_be, 4'b1100);
      check($sformatf("sh_wdata_%0d", k), dmem_wdata, 32'hBEEF_BEEF);
      check($sformatf("sh_addr_%0d", k), dmem_addr, 32'h2000);
      check($sformatf("sh_stall_%0d", k), stall_o, 1);
      tick();
    end
    dmem_ready = 1;
    #1;
    check("sh_req_acc", dmem_req, 1);
    check("sh_we", dmem_we, 1);
    check("sh_stall_acc", stall_o, 0);
    tick();
    dmem_ready = 0;
    ex_valid   = 0;
    check("sh_wb_valid", wb_valid, 1);
    check("sh_regw", wb_regw, 1);
    check("sh_result", wb_result, 32'h55);
    tick();
    check("sh_wb_once", wb_valid, 0);
    check("sh_writes", writes, 1);
    check("sh_req_done", dmem_req, 0);

    // Load accepted but never answered: bus timeout
    set_op(1, 0, 2'b10, 0, 32'h50, 32'h0, 32'h77, M2R_LOAD, 1, 6);
    tick();
    dmem_ready = 1;
    #1;
    hi = 0;
    for (int k = 0; k < 20; k++) begin
      if (!stall_o) break;
      hi++;
      tick();
      dmem_ready = 0;
    end
    check("to_stall_cycles", hi, 8);
    check("to_req_abort", dmem_req, 0);
    tick();
    ex_valid = 0;
    check("to_bus_err", bus_err_o, 1);
    check("to_wb_valid", wb_valid, 1);
    check("to_regw", wb_regw, 0);
    check("to_rd", wb_rd, 6);
    set_op(0, 0, 2'b10, 0, 32'h0, 32'h0, 32'h99, M2R_ALU, 1, 2);
    #1 check("to_next_stall", stall_o, 0);
    tick();
    ex_valid = 0;
    check("to_next_valid", wb_valid, 1);
    check("to_next_result", wb_result, 32'h99);
    check("to_next_buserr", bus_err_o, 0);

    // Flush during WAIT on an unsigned half load
    set_op(1, 0, 2'b01, 1, 32'h62, 32'h0, 32'h0, M2R_LOAD, 1, 9);
    tick();
    dmem_ready = 1;
    tick();
    dmem_ready = 0;
    flush_i    = 1;
    #1 check("fl_stall_wait", stall_o, 1);
    tick();
    flush_i     = 0;
    dmem_rvalid = 1;
    dmem_rdata  = 32'h8765_CAFE;
    #1 check("fl_stall_done", stall_o, 0);
    tick();
    dmem_rvalid = 0;
    ex_valid    = 0;
    check("fl_wb_valid", wb_valid, 1);
    check("fl_result", wb_result, 32'h0000_8765);
    check("fl_regw", wb_regw, 0);

    // Asynchronous reset in the middle of a store request
    set_op(0, 1, 2'b10, 0, 32'h70, 32'h1122_3344, 32'h0, M2R_ALU, 1, 10);
    tick();
    check("ar_req_before", dmem_req, 1);
    check("ar_wdata_before", dmem_wdata, 32'h1122_3344);
    #2 rst = 1'b0;
    #1;
    check("ar_req", dmem_req, 0);
    check("ar_stall", stall_o, 0);
    check("ar_dmem", {dmem_we, dmem_be, dmem_addr}, 0);
    check("ar_wdata", dmem_wdata, 0);
    check("ar_wb", {wb_valid, wb_regw, wb_mem2reg, wb_rd}, 0);
    check("ar_wb_result", wb_result, 0);
    tick();
    check("ar_stall_held", stall_o, 0);
    rst      = 1'b1;
    ex_valid = 0;
    tick();
    check("ar_idle_req", dmem_req, 0);
    check("ar_idle_valid", wb_valid, 0);
    set_op(0, 0, 2'b10, 0, 32'h0, 32'h0, 32'hC0DE, M2R_ALU, 1, 13);
    tick();
    ex_valid = 0;
    check("ar_next_valid", wb_valid, 1);
    check("ar_next_result", wb_result, 32'hC0DE);
    check("ar_next_rd", wb_rd, 13);
    check("ar_writes", writes, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
